// File: rtl/dmem_mmio.sv
// Data-memory stage for the pipelined CPU: word RAM with byte/half access and
// sign/zero extension, plus a 4-register MMIO window (LED, SW, CYCLE, STATUS).
module dmem_mmio #(
    parameter int          DEPTH   = 1024,
    parameter logic [31:0] IO_BASE = 32'hFFFF_0000,
    parameter int          SW_W    = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            mem_w,
    input  logic            mem_r,
    input  logic [31:0]     addr,
    input  logic [31:0]     din,
    input  logic [2:0]      dm_type,
    output logic [31:0]     dout,
    input  logic [SW_W-1:0] sw_i,
    output logic [SW_W-1:0] led_o,
    output logic            fault_o
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [2:0] T_WORD = 3'b000;
    localparam logic [2:0] T_HS   = 3'b001;
    localparam logic [2:0] T_HU   = 3'b010;
    localparam logic [2:0] T_BS   = 3'b011;
    localparam logic [2:0] T_BU   = 3'b100;

    logic [31:0]     ram [DEPTH];

    logic [SW_W-1:0] led;
    logic [SW_W-1:0] sw_p0;
    logic [SW_W-1:0] sw_p1;
    logic [31:0]     cycle_cnt;
    logic [1:0]      status;
    logic [1:0]      status_next;
    logic            fault_p1;

    logic            is_ram;
    logic            is_io;
    logic            mapped;
    logic            legal;
    logic            misalign;
    logic            io_sub;
    logic            bad_align;
    logic            access;
    logic            fault_ev;
    logic            ok;
    logic            st_ram;
    logic            st_io;
    logic            status_clr;
    logic [AW-1:0]   widx;
    logic [1:0]      lane;
    logic [1:0]      io_off;
    logic [3:0]      be;
    logic [31:0]     wdata;
    logic [31:0]     rword;
    logic [31:0]     io_word;

    // Lane extraction and extension of a RAM word for sub-word loads.
    function automatic logic [31:0] load_ext(input logic [31:0] w,
                                             input logic [1:0]  ln,
                                             input logic [2:0]  t);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic signed [31:0] r;
        b = w[{ln, 3'b000} +: 8];
        h = ln[1] ? w[31:16] : w[15:0];
        case (t)
            T_HS:    r = 32'(h);
            T_HU:    r = {16'h0000, h};
            T_BS:    r = 32'(b);
            T_BU:    r = {24'h00_0000, b};
            default: r = w;
        endcase
        return r;
    endfunction

    assign is_ram = (addr[31:AW+2] == '0);
    assign is_io  = (addr[31:4] == IO_BASE[31:4]);
    assign mapped = is_ram | is_io;
    assign legal  = (dm_type <= T_BU);
    assign widx   = addr[AW+1:2];
    assign lane   = addr[1:0];
    assign io_off = addr[3:2];
    assign access = mem_r | mem_w;

    always_comb begin
        misalign = 1'b0;
        case (dm_type)
            T_WORD:     misalign = (addr[1:0] != 2'b00);
            T_HS, T_HU: misalign = addr[0];
            default:    misalign = 1'b0;
        endcase
    end

    // IO registers only respond to word accesses; sub-word IO counts as misalignment.
    assign io_sub    = is_io && legal && (dm_type != T_WORD);
    assign bad_align = misalign | io_sub;
    assign fault_ev  = access && mapped && (bad_align || !legal);
    assign ok        = mapped && legal && !bad_align;
    assign st_ram    = mem_w && !reset && ok && is_ram;
    assign st_io     = mem_w && !reset && ok && is_io;

    always_comb begin
        be    = 4'b0000;
        wdata = din;
        case (dm_type)
            T_WORD: be = 4'b1111;
            T_HS, T_HU: begin
                be    = addr[1] ? 4'b1100 : 4'b0011;
                wdata = {2{din[15:0]}};
            end
            T_BS, T_BU: begin
                be    = 4'b0001 << addr[1:0];
                wdata = {4{din[7:0]}};
            end
            default: be = 4'b0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (st_ram) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) ram[widx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    // A clearing write and a same-edge fault: the fault bit is OR-ed in last.
    assign status_clr  = st_io && (io_off == 2'd3);
    assign status_next = (status_clr ? 2'b00 : status)
                       | {fault_ev & ~legal, fault_ev & bad_align};

    always_ff @(posedge clk) begin
        if (reset) begin
            led       <= '0;
            sw_p0     <= '0;
            sw_p1     <= '0;
            cycle_cnt <= '0;
            status    <= '0;
            fault_p1  <= 1'b0;
        end else begin
            sw_p0    <= sw_i;
            sw_p1    <= sw_p0;
            fault_p1 <= fault_ev;
            status   <= status_next;
            if (st_io && (io_off == 2'd0)) led <= din[SW_W-1:0];
            if (st_io && (io_off == 2'd2)) cycle_cnt <= din;
            else                            cycle_cnt <= cycle_cnt + 32'd1;
        end
    end

    assign rword = ram[widx];

    always_comb begin
        io_word = '0;
        case (io_off)
            2'd0:    io_word = 32'(led);
            2'd1:    io_word = 32'(sw_p1);
            2'd2:    io_word = cycle_cnt;
            default: io_word = {30'd0, status};
        endcase
    end

    // Zero-latency load path; RAM read is the pre-edge contents.
    assign dout    = (mem_r && ok) ? (is_ram ? load_ext(rword, lane, dm_type) : io_word) : 32'd0;
    assign led_o   = led;
    assign fault_o = fault_p1;

endmodule

// File: tb/tb_dmem_mmio.sv
// Self-checking bench for dmem_mmio: directed scenarios plus randomized
// accesses against a byte-addressed behavioural model.
module tb_dmem_mmio;

    localparam int          DEPTH = 1024;
    localparam logic [31:0] IOB   = 32'hFFFF_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        mem_w = 1'b0;
    logic        mem_r = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [31:0] din = 32'd0;
    logic [2:0]  dm_type = 3'd0;
    logic [31:0] dout;
    logic [15:0] sw_i = 16'd0;
    logic [15:0] led_o;
    logic        fault_o;

    always #5 clk = ~clk;

    dmem_mmio #(.DEPTH(DEPTH), .IO_BASE(IOB), .SW_W(16)) dut (
        .clk(clk), .reset(reset), .mem_w(mem_w), .mem_r(mem_r), .addr(addr),
        .din(din), .dm_type(dm_type), .dout(dout), .sw_i(sw_i), .led_o(led_o),
        .fault_o(fault_o)
    );

    // Reference model state
    logic [7:0]  mb [4*DEPTH];
    logic [15:0] m_led = 16'd0;
    logic [31:0] m_cyc = 32'd0;
    logic [1:0]  m_status = 2'd0;
    logic        m_fault = 1'b0;
    logic [15:0] sw_hist [$];
    logic [31:0] exp_d;
    int          vecs = 0;
    int          errs = 0;

    task automatic drive(input logic rs, input logic w, input logic r, input logic [31:0] a,
                         input logic [31:0] d, input logic [2:0] t, output logic [31:0] got);
        int          sz;
        logic        in_ram, in_io, ill, mis, flt;
        logic [31:0] off, v, nc;
        logic [11:0] ba;
        reset = rs; mem_w = w; mem_r = r; addr = a; din = d; dm_type = t;
        in_ram = (a < 32'(4*DEPTH));
        in_io  = (a >= IOB) && ((a - IOB) < 32'd16);
        off    = (a - IOB) >> 2;
        sz     = (t == 3'd0) ? 4 : ((t <= 3'd2) ? 2 : 1);
        ill    = (t > 3'd4);
        mis    = !ill && (((sz == 4) && (a[1:0] != 2'b00)) || ((sz == 2) && a[0]) || (in_io && t != 3'd0));
        flt    = (w || r) && (in_ram || in_io) && (ill || mis);
        exp_d  = 32'd0;
        if (r && (in_ram || in_io) && !ill && !mis) begin
            if (in_ram) begin
                v = 32'd0;
                for (int i = 0; i < sz; i++) begin
                    ba = a[11:0] + 12'(i);
                    v = v | (32'(mb[ba]) << (8*i));
                end
                if (t == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
                if (t == 3'd3 && v[7])  v = v | 32'hFFFF_FF00;
                exp_d = v;
            end else begin
                case (off[1:0])
                    2'd0: exp_d = {16'd0, m_led};
                    2'd1: exp_d = (sw_hist.size() >= 2) ? {16'd0, sw_hist[sw_hist.size()-2]} : 32'd0;
                    2'd2: exp_d = m_cyc;
                    default: exp_d = {30'd0, m_status};
                endcase
            end
        end
        #2 got = dout;
        @(posedge clk);
        if (rs) begin
            m_led = 16'd0; m_cyc = 32'd0; m_status = 2'd0;
            sw_hist.delete();
        end else begin
            nc = m_cyc + 32'd1;
            if (w && (in_ram || in_io) && !ill && !mis) begin
                if (in_ram) begin
                    for (int i = 0; i < sz; i++) begin
                        ba = a[11:0] + 12'(i);
                        mb[ba] = d[8*i +: 8];
                    end
                end else if (off[1:0] == 2'd0) m_led = d[15:0];
                else if (off[1:0] == 2'd2) nc = d;
                else if (off[1:0] == 2'd3) m_status = 2'd0;
            end
            if (flt) m_status = m_status | (ill ? 2'b10 : 2'b01);
            m_cyc = nc;
            sw_hist.push_back(sw_i);
        end
        m_fault = !rs && flt;
        #1;
        mem_w = 1'b0; mem_r = 1'b0; reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] got;
        drive(1, 0, 0, 32'd0, 32'd0, 3'd0, got);
        drive(1, 1, 0, 32'h40, 32'h1234_5678, 3'd0, got);
        vecs++; if (fault_o !== 1'b0) begin errs++; $display("FAIL rst_fault got %b want 0", fault_o); end
        vecs++; if (led_o !== 16'd0) begin errs++; $display("FAIL rst_led got %h want 0000", led_o); end
        drive(0, 0, 1, IOB + 32'd8, 32'd0, 3'd0, got);
        vecs++; if (got !== 32'd0) begin errs++; $display("FAIL rst_cycle got %h want 0", got); end
        drive(0, 0, 1, IOB + 32'd12, 32'd0, 3'd0, got);
        vecs++; if (got !== 32'd0) begin errs++; $display("FAIL rst_status got %h want 0", got); end
        for (int i = 0; i < 64; i++) drive(0, 1, 0, 32'(4*i), 32'd0, 3'd0, got);
    endtask

    task automatic test_subword_load();
        logic [31:0] got;
        drive(0, 1, 0, 32'h10, 32'h8000_00F1, 3'd0, got);
        drive(0, 0, 1, 32'h10, 32'd0, 3'd3, got);
        vecs++; if (got !== 32'hFFFF_FFF1) begin errs++; $display("FAIL lb got %h want FFFFFFF1", got); end
        drive(0, 0, 1, 32'h10, 32'd0, 3'd4, got);
        vecs++; if (got !== 32'h0000_00F1) begin errs++; $display("FAIL lbu got %h want 000000F1", got); end
        drive(0, 0, 1, 32'h12, 32'd0, 3'd2, got);
        vecs++; if (got !== 32'h0000_8000) begin errs++; $display("FAIL lhu got %h want 00008000", got); end
        drive(0, 0, 1, 32'h12, 32'd0, 3'd1, got);
        vecs++; if (got !== 32'hFFFF_8000) begin errs++; $display("FAIL lh got %h want FFFF8000", got); end
    endtask

    task automatic test_subword_store();
        logic [31:0] got;
        drive(0, 1, 0, 32'h20, 32'hAABB_CCDD, 3'd0, got);
        drive(0, 1, 0, 32'h22, 32'h0000_0011, 3'd3, got);
        drive(0, 0, 1, 32'h20, 32'd0, 3'd0, got);
        vecs++; if (got !== 32'hAA11_CCDD) begin errs++; $display("FAIL sb got %h want AA11CCDD", got); end
        drive(0, 1, 0, 32'h20, 32'h0000_7777, 3'd1, got);
        drive(0, 0, 1, 32'h20, 32'd0, 3'd0, got);
        vecs++; if (got !== 32'hAA11_7777) begin errs++; $display("FAIL sh got %h want AA117777", got); end
    endtask

    task automatic test_misalign();
        logic [31:0] got;
        drive(0, 0, 1, 32'h21, 32'd0, 3'd0, got);
        vecs++; if (got !== 32'd0) begin errs++; $display("FAIL mis_dout got %h want 0", got); end
        vecs++; if (fault_o !== 1'b1) begin errs++; $display("FAIL mis_fault got %b want 1", fault_o); end
        drive(0, 0, 1, IOB + 32'd12, 32'd0, 3'd0, got);
        vecs++; if (fault_o !== 1'b0) begin errs++; $display("FAIL mis_pulse got %b want 0", fault_o); end
        vecs++; if (got !== 32'd1) begin errs++; $display("FAIL mis_status got %h want 1", got); end
        drive(0, 1, 0, IOB + 32'd12, 32'd0, 3'd0, got);
        drive(0, 0, 1, IOB + 32'd12, 32'd0, 3'd0, got);
        vecs++; if (got !== 32'd0) begin errs++; $display("FAIL status_clr got %h want 0", got); end
        drive(0, 1, 0, 32'h22, 32'hDEAD_BEEF, 3'd0, got);
        vecs++; if (fault_o !== 1'b1) begin errs++; $display("FAIL mis_st_fault got %b want 1", fault_o); end
        drive(0, 0, 1, 32'h20, 32'd0, 3'd0, got);
        vecs++; if (got !== 32'hAA11_7777) begin errs++; $display("FAIL mis_st_nowrite got %h want AA117777", got); end
        drive(0, 0, 1, IOB + 32'd0, 32'd0, 3'd4, got);
        vecs++; if (got !== 32'd0) begin errs++; $display("FAIL io_sub_dout got %h want 0", got); end
        vecs++; if (fault_o !== 1'b1) begin errs++; $display("FAIL io_sub_fault got %b want 1", fault_o); end
    endtask

    task automatic test_io();
        logic [31:0] got;
        drive(0, 1, 0, IOB, 32'h1234_ABCD, 3'd0, got);
        vecs++; if (led_o !== 16'hABCD) begin errs++; $display("FAIL led_o got %h want ABCD", led_o); end
        drive(0, 0, 1, IOB, 32'd0, 3'd0, got);
        vecs++; if (got !== 32'h0000_ABCD) begin errs++; $display("FAIL led_rd got %h want 0000ABCD", got); end
        sw_i = 16'h5A5A;
        drive(0, 0, 1, IOB + 32'd4, 32'd0, 3'd0, got);
        vecs++; if (got !== 32'd0) begin errs++; $display("FAIL sw_e0 got %h want 0", got); end
        drive(0, 0, 1, IOB + 32'd4, 32'd0, 3'd0, got);
        vecs++; if (got !== 32'd0) begin errs++; $display("FAIL sw_e1 got %h want 0", got); end
        drive(0, 1, 1, IOB + 32'd4, 32'hFFFF_FFFF, 3'd0, got);
        vecs++; if (got !== 32'h0000_5A5A) begin errs++; $display("FAIL sw_e2 got %h want 00005A5A", got); end
        drive(0, 0, 1, IOB + 32'd4, 32'd0, 3'd0, got);
        vecs++; if (got !== 32'h0000_5A5A) begin errs++; $display("FAIL sw_ro got %h want 00005A5A", got); end
    endtask

    task automatic test_cycle();
        logic [31:0] got;
        drive(0, 1, 0, IOB + 32'd8, 32'hFFFF_FFFE, 3'd0, got);
        drive(0, 0, 1, IOB + 32'd8, 32'd0, 3'd0, got);
        vecs++; if (got !== 32'hFFFF_FFFE) begin errs++; $display("FAIL cyc_load got %h want FFFFFFFE", got); end
        drive(0, 0, 1, IOB + 32'd8, 32'd0, 3'd0, got);
        vecs++; if (got !== 32'hFFFF_FFFF) begin errs++; $display("FAIL cyc_inc got %h want FFFFFFFF", got); end
        drive(0, 0, 1, IOB + 32'd8, 32'd0, 3'd0, got);
        vecs++; if (got !== 32'd0) begin errs++; $display("FAIL cyc_wrap got %h want 0", got); end
        drive(0, 0, 0, 32'd0, 32'd0, 3'd0, got);
        drive(1, 1, 0, 32'h20, 32'h5555_5555, 3'd0, got);
        drive(0, 0, 1, IOB + 32'd8, 32'd0, 3'd0, got);
        vecs++; if (got !== 32'd0) begin errs++; $display("FAIL cyc_rst got %h want 0", got); end
        vecs++; if (led_o !== 16'd0) begin errs++; $display("FAIL led_rst got %h want 0000", led_o); end
        drive(0, 0, 1, 32'h20, 32'd0, 3'd0, got);
        vecs++; if (got !== 32'hAA11_7777) begin errs++; $display("FAIL rst_store got %h want AA117777", got); end
    endtask

    task automatic test_illegal_unmapped();
        logic [31:0] got;
        drive(0, 0, 1, 32'h0, 32'd0, 3'd5, got);
        vecs++; if (got !== 32'd0) begin errs++; $display("FAIL ill_dout got %h want 0", got); end
        vecs++; if (fault_o !== 1'b1) begin errs++; $display("FAIL ill_fault got %b want 1", fault_o); end
        drive(0, 0, 1, IOB + 32'd12, 32'd0, 3'd0, got);
        vecs++; if (got !== 32'd2) begin errs++; $display("FAIL ill_status got %h want 2", got); end
        drive(0, 1, 1, 32'h8000_0000, 32'h1357_9BDF, 3'd0, got);
        vecs++; if (got !== 32'd0) begin errs++; $display("FAIL unm_dout got %h want 0", got); end
        vecs++; if (fault_o !== 1'b0) begin errs++; $display("FAIL unm_fault got %b want 0", fault_o); end
        drive(0, 0, 1, 32'h0, 32'd0, 3'd0, got);
        vecs++; if (got !== 32'd0) begin errs++; $display("FAIL unm_nowrite got %h want 0", got); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] got;
        drive(0, 0, 1, 32'h21, 32'd0, 3'd0, got);
        vecs++; if (fault_o !== 1'b1) begin errs++; $display("FAIL b2b_f1 got %b want 1", fault_o); end
        drive(0, 1, 0, 32'h23, 32'd0, 3'd1, got);
        vecs++; if (fault_o !== 1'b1) begin errs++; $display("FAIL b2b_f2 got %b want 1", fault_o); end
        drive(0, 1, 1, 32'h30, 32'hCAFE_F00D, 3'd0, got);
        vecs++; if (got !== 32'd0) begin errs++; $display("FAIL rw_old got %h want 0", got); end
        vecs++; if (fault_o !== 1'b0) begin errs++; $display("FAIL rw_fault got %b want 0", fault_o); end
        drive(0, 0, 1, 32'h30, 32'd0, 3'd0, got);
        vecs++; if (got !== 32'hCAFE_F00D) begin errs++; $display("FAIL rw_new got %h want CAFEF00D", got); end
    endtask

    task automatic test_random();
        logic [31:0] got, a;
        logic [2:0]  t;
        logic        w, r;
        for (int n = 0; n < 400; n++) begin
            t = 3'($urandom_range(0, 5));
            if ($urandom_range(0, 9) < 8) begin
                a = 32'($urandom_range(0, 255));
            end else begin
                a = IOB + 32'($urandom_range(0, 15));
                if ($urandom_range(0, 3) != 0) begin
                    t = 3'd0;
                    a[1:0] = 2'b00;
                end
            end
            w = ($urandom_range(0, 2) == 0);
            r = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 7) == 0) sw_i = 16'($urandom);
            drive(0, w, r, a, $urandom, t, got);
            vecs++; if (got !== exp_d) begin errs++; $display("FAIL rnd_dout a=%h t=%0d got %h want %h", a, t, got, exp_d); end
            vecs++; if (fault_o !== m_fault) begin errs++; $display("FAIL rnd_fault a=%h t=%0d got %b want %b", a, t, fault_o, m_fault); end
            vecs++; if (led_o !== m_led) begin errs++; $display("FAIL rnd_led got %h want %h", led_o, m_led); end
        end
    endtask

    initial begin
        for (int i = 0; i < 4*DEPTH; i++) mb[i] = 8'd0;
        test_reset();
        test_subword_load();
        test_subword_store();
        test_misalign();
        test_io();
        test_cycle();
        test_illegal_unmapped();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
